// File: rtl/game_pkg.sv
// Shared types and encodings for the game frame sequencer and its helpers.
package game_pkg;

  typedef enum logic [1:0] {
    G_READY = 2'd0,
    G_PLAY  = 2'd1,
    G_OVER  = 2'd2
  } game_state_t;

  typedef enum logic [1:0] {
    F_WAIT = 2'd0,
    F_PHYS = 2'd1,
    F_COLL = 2'd2,
    F_REND = 2'd3
  } frame_state_t;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  localparam int TICK_DIV_DEFAULT = 4;

  // Opposing buttons cancel out so physics never sees a contradictory move.
  function automatic logic [1:0] decode_dir(input logic l, input logic r);
    logic [1:0] d;
    case ({l, r})
      2'b10:   d = DIR_LEFT;
      2'b01:   d = DIR_RIGHT;
      default: d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/game_frame_sequencer_if.sv
// Button inputs, stage handshakes and status outputs of the frame sequencer.
interface game_frame_sequencer_if #(
  parameter int FRAME_W = 16
);
  logic               left;
  logic               right;
  logic               phys_done;
  logic               coll_done;
  logic               fell;
  logic               render_done;
  logic               phys_start;
  logic               coll_start;
  logic               render_start;
  logic [1:0]         move_dir;
  logic               playing;
  logic               game_over;
  logic [FRAME_W-1:0] frame_cnt;
  logic               overrun;

  modport master (
    input  left, right, phys_done, coll_done, fell, render_done,
    output phys_start, coll_start, render_start, move_dir,
           playing, game_over, frame_cnt, overrun
  );

  modport slave (
    output left, right, phys_done, coll_done, fell, render_done,
    input  phys_start, coll_start, render_start, move_dir,
           playing, game_over, frame_cnt, overrun
  );
endinterface

// File: rtl/tick_divider.sv
// Free-running frame tick generator: one-cycle pulse every TICK_DIV clocks.
module tick_divider
  import game_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count 0..TICK_DIV-1 and wrap.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == LAST) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/game_frame_sequencer.sv
// Frame scheduler: runs physics -> collision -> render once per tick and owns
// the READY / PLAY / OVER game state.
module game_frame_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int FRAME_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  game_frame_sequencer_if.master bus
);

  logic tick;

  frame_state_t       frame_q, frame_d;
  game_state_t        game_q, game_d;
  logic [1:0]         dir_q, dir_d;
  logic [FRAME_W-1:0] cnt_q, cnt_d;
  logic               ovr_q, ovr_d;
  logic               play_frame_q, play_frame_d;
  logic               phys_start_q, phys_start_d;
  logic               coll_start_q, coll_start_d;
  logic               render_start_q, render_start_d;
  logic               any_btn;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign any_btn = bus.left | bus.right;

  // Next-state for both FSMs; they share the accepted-tick and done conditions.
  always_comb begin
    frame_d      = frame_q;
    game_d       = game_q;
    dir_d        = dir_q;
    cnt_d        = cnt_q;
    ovr_d        = ovr_q;
    play_frame_d = play_frame_q;

    // A tick while a frame is still in flight is dropped and remembered.
    if (tick && (frame_q != F_WAIT)) ovr_d = 1'b1;

    case (frame_q)
      F_WAIT: begin
        if (tick) begin
          dir_d = decode_dir(bus.left, bus.right);
          case (game_q)
            G_READY: if (any_btn) begin
              game_d = G_PLAY;
              cnt_d  = '0;
            end
            G_OVER:  if (any_btn) game_d = G_READY;
            default: ;
          endcase
          if (game_d == G_PLAY) begin
            frame_d      = F_PHYS;
            play_frame_d = 1'b1;
          end else begin
            frame_d      = F_REND;
            play_frame_d = 1'b0;
          end
        end
      end
      F_PHYS: if (bus.phys_done && !phys_start_q) frame_d = F_COLL;
      F_COLL: if (bus.coll_done && !coll_start_q) begin
        frame_d = F_REND;
        if (bus.fell && (game_q == G_PLAY)) game_d = G_OVER;
      end
      F_REND: if (bus.render_done && !render_start_q) begin
        frame_d = F_WAIT;
        if (play_frame_q) cnt_d = cnt_q + FRAME_W'(1);
      end
      default: frame_d = F_WAIT;
    endcase

    // Strobes fire only in the first cycle of each stage state.
    phys_start_d   = (frame_d == F_PHYS) && (frame_q != F_PHYS);
    coll_start_d   = (frame_d == F_COLL) && (frame_q != F_COLL);
    render_start_d = (frame_d == F_REND) && (frame_q != F_REND);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q        <= F_WAIT;
      game_q         <= G_READY;
      dir_q          <= DIR_NONE;
      cnt_q          <= '0;
      ovr_q          <= 1'b0;
      play_frame_q   <= 1'b0;
      phys_start_q   <= 1'b0;
      coll_start_q   <= 1'b0;
      render_start_q <= 1'b0;
    end else begin
      frame_q        <= frame_d;
      game_q         <= game_d;
      dir_q          <= dir_d;
      cnt_q          <= cnt_d;
      ovr_q          <= ovr_d;
      play_frame_q   <= play_frame_d;
      phys_start_q   <= phys_start_d;
      coll_start_q   <= coll_start_d;
      render_start_q <= render_start_d;
    end
  end

  assign bus.phys_start   = phys_start_q;
  assign bus.coll_start   = coll_start_q;
  assign bus.render_start = render_start_q;
  assign bus.move_dir     = dir_q;
  assign bus.playing      = (game_q == G_PLAY);
  assign bus.game_over    = (game_q == G_OVER);
  assign bus.frame_cnt    = cnt_q;
  assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_game_frame_sequencer.sv
// Scoreboard bench for game_frame_sequencer: the driver queues the expected
// status seen with every stage strobe, the monitor checks each strobe against it.
module tb_game_frame_sequencer;

  localparam int TDIV = 8;
  localparam int FW   = 16;

  localparam logic [2:0] K_PHYS = 3'b001;
  localparam logic [2:0] K_COLL = 3'b010;
  localparam logic [2:0] K_REND = 3'b100;

  typedef struct packed {
    logic [2:0]    kind;
    logic [1:0]    dir;
    logic          playing;
    logic          over;
    logic [FW-1:0] cnt;
    logic          ovr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t got;
  exp_t want;

  game_frame_sequencer_if #(.FRAME_W(FW)) bus ();

  game_frame_sequencer #(.TICK_DIV(TDIV), .FRAME_W(FW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!reset && (bus.phys_start || bus.coll_start || bus.render_start)) begin
      got.kind    = {bus.render_start, bus.coll_start, bus.phys_start};
      got.dir     = bus.move_dir;
      got.playing = bus.playing;
      got.over    = bus.game_over;
      got.cnt     = bus.frame_cnt;
      got.ovr     = bus.overrun;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL strobe_unexpected: got kind=%b at cycle %0d, required no strobe", got.kind, cyc);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL strobe_cmp: got kind=%b dir=%b play=%b over=%b cnt=%0d ovr=%b, required kind=%b dir=%b play=%b over=%b cnt=%0d ovr=%b",
                   got.kind, got.dir, got.playing, got.over, got.cnt, got.ovr,
                   want.kind, want.dir, want.playing, want.over, want.cnt, want.ovr);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic [1:0] d, input logic p,
                      input logic o, input logic [FW-1:0] c, input logic v);
    exp_t e;
    e.kind = k; e.dir = d; e.playing = p; e.over = o; e.cnt = c; e.ovr = v;
    exp_q.push_back(e);
  endtask

  function automatic logic strobe_of(input logic [2:0] k);
    return |(k & {bus.render_start, bus.coll_start, bus.phys_start});
  endfunction

  task automatic wait_strobe(input logic [2:0] k, output int at_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (strobe_of(k)) seen = 1'b1;
      else @(negedge clk);
    end
    at_cyc = cyc;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wait_strobe_%b: got no strobe within 40 cycles, required one", k);
    end
  endtask

  task automatic respond(input logic [2:0] k, input int delay, input logic fell_v);
    repeat (delay) @(negedge clk);
    bus.phys_done   = k[0];
    bus.coll_done   = k[1];
    bus.render_done = k[2];
    bus.fell        = fell_v;
    @(negedge clk);
    bus.phys_done   = 1'b0;
    bus.coll_done   = 1'b0;
    bus.render_done = 1'b0;
    bus.fell        = 1'b0;
  endtask

  task automatic push_play(input logic [1:0] d, input logic [FW-1:0] c, input logic v);
    push(K_PHYS, d, 1'b1, 1'b0, c, v);
    push(K_COLL, d, 1'b1, 1'b0, c, v);
    push(K_REND, d, 1'b1, 1'b0, c, v);
  endtask

  task automatic run_play(input logic fell_v, input int rend_delay);
    int c;
    wait_strobe(K_PHYS, c);
    bus.left = 1'b0; bus.right = 1'b0;
    respond(K_PHYS, 1, 1'b0);
    wait_strobe(K_COLL, c);
    respond(K_COLL, 1, fell_v);
    wait_strobe(K_REND, c);
    respond(K_REND, rend_delay, 1'b0);
  endtask

  function automatic logic [31:0] all_outs();
    return {8'h0, bus.phys_start, bus.coll_start, bus.render_start, bus.move_dir,
            bus.playing, bus.game_over, bus.overrun, bus.frame_cnt};
  endfunction

  initial begin
    int c, prev, rel;
    bus.left = 1'b0; bus.right = 1'b0;
    bus.phys_done = 1'b0; bus.coll_done = 1'b0; bus.render_done = 1'b0; bus.fell = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), 32'h0);
    reset = 1'b0;
    rel = cyc;

    // Idle in READY: render-only frames, one per tick.
    repeat (3) push(K_REND, 2'b00, 1'b0, 1'b0, 16'd0, 1'b0);
    prev = rel;
    for (int i = 0; i < 3; i++) begin
      wait_strobe(K_REND, c);
      chk("render_period", c - prev, TDIV);
      prev = c;
      respond(K_REND, 1, 1'b0);
    end
    chk("idle_playing", {31'h0, bus.playing}, 32'h0);
    chk("idle_frame_cnt", {16'h0, bus.frame_cnt}, 32'h0);

    // Right at a tick starts play with a physics frame.
    bus.right = 1'b1;
    push_play(2'b10, 16'd0, 1'b0);
    run_play(1'b0, 1);
    chk("first_play_cnt", {16'h0, bus.frame_cnt}, 32'd1);
    chk("first_play_playing", {31'h0, bus.playing}, 32'd1);

    // Both buttons cancel, then left alone.
    bus.left = 1'b1; bus.right = 1'b1;
    push_play(2'b00, 16'd1, 1'b0);
    run_play(1'b0, 1);
    chk("both_cnt", {16'h0, bus.frame_cnt}, 32'd2);
    bus.left = 1'b1;
    push_play(2'b01, 16'd2, 1'b0);
    run_play(1'b0, 1);
    chk("left_cnt", {16'h0, bus.frame_cnt}, 32'd3);

    // Slow render overruns the next tick; the frame still counts once.
    push_play(2'b00, 16'd3, 1'b0);
    run_play(1'b0, 6);
    chk("overrun_set", {31'h0, bus.overrun}, 32'd1);
    chk("overrun_cnt_once", {16'h0, bus.frame_cnt}, 32'd4);
    push_play(2'b00, 16'd4, 1'b1);
    run_play(1'b0, 1);
    chk("overrun_sticky", {31'h0, bus.overrun}, 32'd1);
    chk("after_overrun_cnt", {16'h0, bus.frame_cnt}, 32'd5);

    // Fall ends the game at the collision edge; render still runs.
    push(K_PHYS, 2'b00, 1'b1, 1'b0, 16'd5, 1'b1);
    push(K_COLL, 2'b00, 1'b1, 1'b0, 16'd5, 1'b1);
    push(K_REND, 2'b00, 1'b0, 1'b1, 16'd5, 1'b1);
    run_play(1'b1, 1);
    chk("over_game_over", {31'h0, bus.game_over}, 32'd1);
    chk("over_playing", {31'h0, bus.playing}, 32'd0);
    chk("over_cnt", {16'h0, bus.frame_cnt}, 32'd6);
    push(K_REND, 2'b00, 1'b0, 1'b1, 16'd6, 1'b1);
    wait_strobe(K_REND, c);
    respond(K_REND, 1, 1'b0);
    bus.right = 1'b1;
    push(K_REND, 2'b10, 1'b0, 1'b0, 16'd6, 1'b1);
    wait_strobe(K_REND, c);
    bus.right = 1'b0;
    respond(K_REND, 1, 1'b0);
    chk("back_to_ready", {30'h0, bus.game_over, bus.playing}, 32'd0);
    chk("ready_cnt_kept", {16'h0, bus.frame_cnt}, 32'd6);

    // Reset in the middle of collision aborts the frame immediately.
    bus.right = 1'b1;
    push(K_PHYS, 2'b10, 1'b1, 1'b0, 16'd0, 1'b1);
    push(K_COLL, 2'b10, 1'b1, 1'b0, 16'd0, 1'b1);
    wait_strobe(K_PHYS, c);
    bus.right = 1'b0;
    respond(K_PHYS, 1, 1'b0);
    wait_strobe(K_COLL, c);
    #2 reset = 1'b1;
    #1 chk("midframe_reset_outputs", all_outs(), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rel = cyc;
    push(K_REND, 2'b00, 1'b0, 1'b0, 16'd0, 1'b0);
    wait_strobe(K_REND, c);
    chk("first_tick_after_reset", c - rel, TDIV);
    respond(K_REND, 1, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_frame_sequencer.md
Name: game_frame_sequencer

Overview:
- Central scheduler for the game box: divides `clk` into frame ticks and runs one frame pipeline per tick (physics -> collision -> render) via start/done handshakes to each stage.
- Owns top-level game state (READY / PLAY / OVER).
- Latches the player's left/right input once per frame, so physics sees a stable move direction.
- Sits between the input buttons and the physics, collision and render stages; it is the sole producer of the physics update strobe.

Parameters:
- TICK_DIV, 4, clocks per frame tick (>=2).
- FRAME_W, 16, width of the frame counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- left  in  1  left button, level.
- right  in  1  right button, level.
- phys_done  in  1  physics stage finished current frame.
- coll_done  in  1  collision stage finished current frame.
- fell  in  1  collision verdict, doodle below screen; valid with coll_done.
- render_done  in  1  render stage finished writing the screen.
- phys_start  out  1  one-cycle physics update strobe.
- coll_start  out  1  one-cycle collision start strobe.
- render_start  out  1  one-cycle render start strobe.
- move_dir  out  2  latched direction: 00 none, 01 left, 10 right.
- playing  out  1  high in G_PLAY.
- game_over  out  1  high in G_OVER.
- frame_cnt  out  FRAME_W  completed frames since entering G_PLAY.
- overrun  out  1  sticky: a tick arrived while a frame was in flight.

Behaviour:
- Reset (async, immediate): all outputs 0, tick counter 0, frame FSM F_WAIT, game FSM G_READY.
- Tick counter:
  - counts 0..TICK_DIV-1 and wraps.
  - `tick` is internal, high for the one cycle where count == TICK_DIV-1.
- Frame FSM states: F_WAIT, F_PHYS, F_COLL, F_REND.
  - F_WAIT + tick:
    - latch move_dir: left only -> 01; right only -> 10; both or neither -> 00.
    - G_PLAY -> F_PHYS; otherwise -> F_REND (no physics outside play).
  - Strobes are registered and high only in the first cycle of their state, so phys_start rises the cycle after the tick.
  - A done input is ignored in the strobe cycle and honoured in any later cycle of that state.
  - F_PHYS + phys_done -> F_COLL.
  - F_COLL + coll_done -> F_REND. If `fell` is also high, game FSM moves G_PLAY -> G_OVER in the same edge.
  - F_REND + render_done -> F_WAIT. frame_cnt increments only if the frame began in G_PLAY, and wraps at 2^FRAME_W.
- Overrun:
  - a tick while the frame FSM is not in F_WAIT sets `overrun` (sticky until reset) and is dropped.
  - A tick in the same cycle as render_done is also dropped; the frame FSM is not yet in F_WAIT.
- Game FSM:
  - G_READY -> G_PLAY at a tick with left|right high. frame_cnt clears to 0 on this transition, and the same tick starts a play frame with phys_start.
  - G_OVER -> G_READY at a tick with left|right high. That frame renders only.
- Done inputs outside their own state are ignored. `fell` without coll_done is ignored.
- Reset mid-frame aborts immediately. No strobe is emitted on reset release until the next tick.
- playing and game_over are decoded from registered state, so they have zero-cycle latency after the state edge.

Decomposition:
- Shared package `game_pkg`:
  - enum for game state (G_READY, G_PLAY, G_OVER).
  - enum for frame state.
  - move_dir encodings DIR_NONE/DIR_LEFT/DIR_RIGHT.
  - default TICK_DIV.
- One natural sub-module: `tick_divider` (counter + tick pulse).
- Both FSMs stay in the top module; they share transition conditions.

Test Plan:
- Reset release, no buttons, TICK_DIV=4 -> render_start pulse every 4 cycles (render_done returned 1 cycle later); phys_start never; playing=0; frame_cnt=0.
- right held across a tick in G_READY -> playing=1, frame_cnt=0, phys_start next cycle, move_dir=10; after phys_done, coll_done(fell=0), render_done -> frame_cnt=1.
- left and right both high at a tick in G_PLAY -> move_dir=00; left alone at the next tick -> 01.
- render_done withheld for 6 cycles -> overrun=1 and stays 1; frame_cnt increments once for that frame, not twice.
- coll_done with fell=1 -> game_over=1 and playing=0 at that edge; the next ticks produce render_start only. right at a tick -> G_READY, game_over=0.
- reset asserted in F_COLL between clock edges -> all outputs 0 immediately; after release the first strobe is render_start at the first tick.
